// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types plus the arbiter state type and round-robin pick helper.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int RR_MAX = 32;
    localparam int RR_IW  = 5;

    typedef struct packed {
        logic             valid;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // First asserted req at or after ptr, wrapping modulo n (n <= RR_MAX).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !res.valid && req[idx[RR_IW-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = idx[RR_IW-1:0];
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/memory_arbiter_rr_arbiter.sv
// Combinational round-robin picker: request vector + pointer -> grant index/valid.
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   grant,
    output logic            valid
);
    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(RR_MAX'(req), int'(ptr), NREQ);
        grant = IW'(pick.idx);
        valid = pick.valid;
    end
endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port among an icache and dcache per CPU with a held round-robin grant.
// Optional MEMARB_DPRIO_EN: dcache requests are scanned before any icache request.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [CPUS-1:0]            iREN,
    input  logic [CPUS-1:0][AW-1:0]    iaddr,
    input  logic [CPUS-1:0]            dREN,
    input  logic [CPUS-1:0]            dWEN,
    input  logic [CPUS-1:0][AW-1:0]    daddr,
    input  logic [CPUS-1:0][DW-1:0]    dstore,
    output logic [CPUS-1:0]            iwait,
    output logic [CPUS-1:0]            dwait,
    output logic [CPUS-1:0][DW-1:0]    iload,
    output logic [CPUS-1:0][DW-1:0]    dload,
    input  ramstate_t                  ramstate,
    input  logic [DW-1:0]              ramload,
    output logic [AW-1:0]              ramaddr,
    output logic [DW-1:0]              ramstore,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [CPUS-1:0]            ccwait,
    output logic [CPUS-1:0]            ccinv,
    output logic [CPUS-1:0][AW-1:0]    ccsnoopaddr
);
    localparam int NREQ = 2 * CPUS;
    localparam int IW   = $clog2(NREQ);

    arb_state_t      state, state_n;
    logic [IW-1:0]   owner, owner_n, rr_ptr, rr_ptr_n, win;
    logic [NREQ-1:0] req;
    logic            win_vld, owner_req;

    // Even index = dcache c, odd index = icache c.
    always_comb begin
        req = '0;
        for (int c = 0; c < CPUS; c++) begin
            req[2*c]   = dREN[c] | dWEN[c];
            req[2*c+1] = iREN[c];
        end
    end

`ifdef MEMARB_DPRIO_EN
    logic [NREQ-1:0] d_mask;
    logic [IW-1:0]   d_win, i_win;
    logic            d_vld, i_vld;

    always_comb begin
        d_mask = '0;
        for (int r = 0; r < NREQ; r++) d_mask[r] = (r % 2 == 0);
    end

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr_d (
        .req(req & d_mask), .ptr(rr_ptr), .grant(d_win), .valid(d_vld)
    );
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr_i (
        .req(req & ~d_mask), .ptr(rr_ptr), .grant(i_win), .valid(i_vld)
    );

    assign win     = d_vld ? d_win : i_win;
    assign win_vld = d_vld | i_vld;
`else
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req(req), .ptr(rr_ptr), .grant(win), .valid(win_vld)
    );
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        case (state)
            ARB_IDLE: begin
                if (win_vld) begin
                    owner_n = win;
                    state_n = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A dropped request aborts without advancing the pointer.
                if (!owner_req) begin
                    state_n = ARB_IDLE;
                end else if (ramstate == ACCESS) begin
                    state_n  = ARB_IDLE;
                    rr_ptr_n = (int'(owner) == NREQ - 1) ? '0 : owner + IW'(1);
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_comb begin
        ramaddr   = '0;
        ramstore  = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        iwait     = '1;
        dwait     = '1;
        iload     = '0;
        dload     = '0;
        owner_req = 1'b0;
        if (state == ARB_BUSY) begin
            for (int c = 0; c < CPUS; c++) begin
                if (int'(owner) == 2 * c) begin
                    owner_req = dREN[c] | dWEN[c];
                    ramaddr   = daddr[c];
                    ramstore  = dstore[c];
                    ramWEN    = dWEN[c];
                    ramREN    = dREN[c] & ~dWEN[c];
                    dload[c]  = ramload;
                    if (ramstate == ACCESS && owner_req) dwait[c] = 1'b0;
                end
                if (int'(owner) == 2 * c + 1) begin
                    owner_req = iREN[c];
                    ramaddr   = iaddr[c];
                    ramREN    = 1'b1;
                    iload[c]  = ramload;
                    if (ramstate == ACCESS && owner_req) iwait[c] = 1'b0;
                end
            end
        end
    end

    assign ccwait      = '0;
    assign ccinv       = '0;
    assign ccsnoopaddr = '0;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed-vector bench for memory_arbiter with CPUS=2 (four requestors).
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                    CLK = 1'b0;
    logic                    nRST;
    logic [CPUS-1:0]         iREN, dREN, dWEN;
    logic [CPUS-1:0][AW-1:0] iaddr, daddr;
    logic [CPUS-1:0][DW-1:0] dstore;
    logic [CPUS-1:0]         iwait, dwait;
    logic [CPUS-1:0][DW-1:0] iload, dload;
    ramstate_t               ramstate;
    logic [DW-1:0]           ramload;
    logic [AW-1:0]           ramaddr;
    logic [DW-1:0]           ramstore;
    logic                    ramREN, ramWEN;
    logic [CPUS-1:0]         ccwait, ccinv;
    logic [CPUS-1:0][AW-1:0] ccsnoopaddr;

    int total = 0;
    int bad   = 0;

    memory_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramstate(ramstate), .ramload(ramload), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with requests already set and the DUT idle; returns at a
    // negedge after the completion edge (DUT back in IDLE).
    task automatic serve(input string tag, input int r, input logic [AW-1:0] exp_addr,
                         input bit wr, input logic [DW-1:0] exp_store, input int nfree);
        logic [1:0]    exp_iw, exp_dw;
        logic [63:0]   exp_il, exp_dl;
        logic [DW-1:0] ld;
        ramstate = FREE;
        #1;
        chk({tag, " idle_en"}, 64'({ramREN, ramWEN}), 64'd0);
        @(negedge CLK); #1;
        chk({tag, " addr"}, 64'(ramaddr), 64'(exp_addr));
        chk({tag, " en"}, 64'({ramREN, ramWEN}), wr ? 64'd1 : 64'd2);
        chk({tag, " store"}, 64'(ramstore), 64'(exp_store));
        repeat (nfree) begin
            chk({tag, " hold_waits"}, 64'({iwait, dwait}), 64'hF);
            @(negedge CLK); #1;
        end
        ld       = 32'hA5A5_0000 + DW'(r);
        ramload  = ld;
        ramstate = ACCESS;
        #1;
        exp_iw = 2'b11; exp_dw = 2'b11; exp_il = '0; exp_dl = '0;
        if (r % 2 == 0) begin
            exp_dw[r/2] = 1'b0;
            exp_dl[(r/2)*32 +: 32] = ld;
        end else begin
            exp_iw[r/2] = 1'b0;
            exp_il[(r/2)*32 +: 32] = ld;
        end
        chk({tag, " iwait"}, 64'(iwait), 64'(exp_iw));
        chk({tag, " dwait"}, 64'(dwait), 64'(exp_dw));
        chk({tag, " iload"}, iload, exp_il);
        chk({tag, " dload"}, dload, exp_dl);
        @(negedge CLK);
        ramstate = FREE;
        ramload  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;
        @(negedge CLK); #1;
        chk("rst_en", 64'({ramREN, ramWEN}), 64'd0);
        chk("rst_addr", 64'(ramaddr), 64'd0);
        chk("rst_store", 64'(ramstore), 64'd0);
        chk("rst_waits", 64'({iwait, dwait}), 64'hF);
        chk("rst_iload", iload, 64'd0);
        chk("rst_dload", dload, 64'd0);
        chk("tie_cc", 64'({ccwait, ccinv}), 64'd0);
        chk("tie_snoop", ccsnoopaddr, 64'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // Single icache read, ACCESS on the third BUSY cycle; ptr -> 2.
        iaddr[0] = 32'h40; iREN = 2'b01;
        serve("single", 1, 32'h40, 1'b0, 32'h0, 2);
        iREN = '0; #1;
        chk("single_once", 64'({iwait, dwait}), 64'hF);
        // ptr=2: r0 and r2 together must pick r2; ptr -> 3.
        daddr[0] = 32'h10; daddr[1] = 32'h20; dREN = 2'b11;
        serve("ptr2", 2, 32'h20, 1'b0, 32'h0, 0);
        dREN = '0;

        // Abort: r1 drops its request while ACCESS is shown.
        iREN = 2'b01; #1;
        chk("abort_idle", 64'({ramREN, ramWEN}), 64'd0);
        @(negedge CLK); #1;
        chk("abort_addr", 64'(ramaddr), 64'h40);
        chk("abort_ren", 64'(ramREN), 64'd1);
        iREN = '0; ramstate = ACCESS; #1;
        chk("abort_no_pulse", 64'({iwait, dwait}), 64'hF);
        @(negedge CLK);
        ramstate = FREE; #1;
        chk("abort_back_idle", 64'({ramREN, ramWEN}), 64'd0);
        // ptr still 3: r2 and r3 together must pick r3; ptr -> 0.
        iaddr[1] = 32'h80; dREN = 2'b10; iREN = 2'b10;
        serve("abort_ptr", 3, 32'h80, 1'b0, 32'h0, 0);
        dREN = '0; iREN = '0;

        // All four held: r0,r1,r2,r3,r0 with ACCESS on every 2nd BUSY cycle; ptr -> 1.
        daddr[0] = 32'h100; iaddr[0] = 32'h200; daddr[1] = 32'h300; iaddr[1] = 32'h400;
        dREN = 2'b11; iREN = 2'b11;
        serve("rr0", 0, 32'h100, 1'b0, 32'h0, 1);
        serve("rr1", 1, 32'h200, 1'b0, 32'h0, 1);
        serve("rr2", 2, 32'h300, 1'b0, 32'h0, 1);
        serve("rr3", 3, 32'h400, 1'b0, 32'h0, 1);
        serve("rr0b", 0, 32'h100, 1'b0, 32'h0, 1);
        dREN = '0; iREN = '0;

        // Write wins over read on the same dcache; ptr=1 -> r2; ptr -> 3.
        daddr[1] = 32'h100; dstore[1] = 32'hDEADBEEF; dREN = 2'b10; dWEN = 2'b10;
        serve("write", 2, 32'h100, 1'b1, 32'hDEADBEEF, 0);
        dREN = '0; dWEN = '0; dstore = '0;

        // Reset in the middle of a BUSY read.
        iaddr[0] = 32'h40; iREN = 2'b01;
        @(negedge CLK); #1;
        chk("mid_ren", 64'(ramREN), 64'd1);
        #1 nRST = 1'b0;
        #1;
        chk("mid_rst_en", 64'({ramREN, ramWEN}), 64'd0);
        chk("mid_rst_addr", 64'(ramaddr), 64'd0);
        chk("mid_rst_waits", 64'({iwait, dwait}), 64'hF);
        chk("mid_rst_iload", iload, 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        daddr[0] = 32'h100; iaddr[0] = 32'h200; daddr[1] = 32'h300; iaddr[1] = 32'h400;
        dREN = 2'b11; iREN = 2'b11;
        serve("post_rst", 0, 32'h100, 1'b0, 32'h0, 0);
        dREN = '0; iREN = '0;

        // iREN[0] and dREN[1] with ptr=0.
        nRST = 1'b0;
        #2 nRST = 1'b1;
        iaddr[0] = 32'h40; daddr[1] = 32'h20; iREN = 2'b01; dREN = 2'b10;
`ifdef MEMARB_DPRIO_EN
        serve("prio_d", 2, 32'h20, 1'b0, 32'h0, 0);
        dREN = '0;
        serve("prio_i", 1, 32'h40, 1'b0, 32'h0, 0);
        iREN = '0;
`else
        serve("plain_i", 1, 32'h40, 1'b0, 32'h0, 0);
        iREN = '0;
        serve("plain_d", 2, 32'h20, 1'b0, 32'h0, 0);
        dREN = '0;
`endif

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
